wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port mem2wb_bus_i, input, `MEM2WBBusSize (102): {wdest[4:0], we, result[31:0], addr[31:0], pc[31:0]}, MSB first.
REQ-004 SHALL have port ctl_mem_over_i, input, 1: MEM holds a completed instruction this cycle.
REQ-005 SHALL have port ctl_wb_allowin_o, output, 1: WB accepts a new instruction at the next edge.
REQ-006 SHALL have port stall_i, input, 1: external hold (debug halt); WB must not retire while high.
REQ-007 SHALL have port rf_we_o, output, 1: register-file write enable.
REQ-008 SHALL have port rf_waddr_o, output, `RegAddrBusW (5): destination register.
REQ-009 SHALL have port rf_wdata_o, output, `RegW (32): write data.
REQ-010 SHALL have port ctl_wb_dest_o, output, 5: valid destination for hazard detection; 0 when invalid.
REQ-011 SHALL have port ctl_wb_pc_o, output, 32: PC held in WB.
REQ-012 SHALL have port debug_wb_pc_o / debug_wb_rf_wen_o (4) / debug_wb_rf_wnum_o (5) / debug_wb_rf_wdata_o (32), outputs: retire trace.
REQ-013 SHALL have port retire_o, output, 1: one-cycle pulse per retired instruction.
REQ-014 SHALL have port instret_o, output, 64: retired-instruction count.

Function
REQ-015 SHALL hold state wb_valid plus one 102-bit pipeline register (wb_bus).
REQ-016 SHALL define ready_go = !stall_i; ctl_wb_allowin_o = !wb_valid | ready_go (combinational).
REQ-017 SHALL, when allowin=1 at an edge, load wb_valid <= ctl_mem_over_i; load wb_bus <= mem2wb_bus_i only if ctl_mem_over_i=1.
REQ-018 SHALL, when allowin=0, hold wb_valid and wb_bus unchanged regardless of ctl_mem_over_i.
REQ-019 SHALL define retire = wb_valid & ready_go; retire_o = retire; latency MEM-over to retire = 1 cycle when unstalled.
REQ-020 SHALL assert rf_we_o = retire & we & (wdest != 0); writes to r0 suppressed; exactly one write per instruction even if stalled for N cycles.
REQ-021 SHALL drive rf_waddr_o = wdest, rf_wdata_o = result directly from wb_bus.
REQ-022 SHALL drive ctl_wb_dest_o = wdest & {5{wb_valid}}, including while stalled.
REQ-023 SHALL drive debug_wb_rf_wen_o = {4{rf_we_o}}, debug_wb_pc_o = pc, debug_wb_rf_wnum_o = wdest, debug_wb_rf_wdata_o = result.
REQ-024 SHALL increment instret_o by 1 on every edge where retire=1, including we=0 instructions; wraps 2^64-1 -> 0 silently.
REQ-025 SHALL, on simultaneous retire and new capture, retire the old instruction and hold the new one next cycle (back-to-back, one per cycle).
REQ-026 SHALL treat addr field as debug-only; not used for any control.

Reset
REQ-027 SHALL, on rst=1 (asynchronous), clear wb_valid, wb_bus and instret to 0; hence rf_we_o=0, retire_o=0, ctl_wb_dest_o=0, all debug outputs 0.
REQ-028 SHALL, on reset during stall, drop the held instruction without a register write or count.
REQ-029 SHALL accept a new instruction on the first edge after rst deasserts.

Structure
REQ-030 SHALL take `MEM2WBBusSize, `RegW, `RegAddrBusW from common.vh; field offsets defined there, not locally.
REQ-031 SHALL instantiate one sub-module, perf_counter64 (enable, async-clear, 64-bit), for instret.

Verification
REQ-032 SHALL check: bus {wdest=5, we=1, result=0xDEADBEEF, pc=0x1C000000}, mem_over=1 one cycle -> next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF, wen=4'hF, instret=1 after edge.
REQ-033 SHALL check: wdest=0, we=1 -> rf_we=0, retire_o=1, instret increments.
REQ-034 SHALL check: stall_i=1 for 3 cycles with valid instruction -> allowin=0, rf_we=0, ctl_wb_dest held; release -> single rf_we pulse, instret +1 only.
REQ-035 SHALL check: 4 back-to-back instructions, stall=0 -> 4 consecutive retire pulses, instret=4.
REQ-036 SHALL check: rst asserted mid-cycle while stalled -> all outputs 0 immediately, no write after deassert.
REQ-037 SHALL check: instret preloaded to 0xFFFF_FFFF_FFFF_FFFF by force, one retire -> 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared widths and the MEM->WB bus layout for the write-back stage.
// The packed struct fixes the field order and offsets, MSB first.
package wb_stage_pkg;

    localparam int unsigned REG_W           = 32;
    localparam int unsigned REG_ADDR_BUS_W  = 5;
    localparam int unsigned MEM2WB_BUS_SIZE = REG_ADDR_BUS_W + 1 + 3 * REG_W;

    typedef struct packed {
        logic [REG_ADDR_BUS_W-1:0] wdest;
        logic                      we;
        logic [REG_W-1:0]          result;
        logic [REG_W-1:0]          addr;
        logic [REG_W-1:0]          pc;
    } mem2wb_bus_t;

endpackage

// File: rtl/wb_stage_perf_counter64.sv
// Free-running 64-bit event counter with enable and asynchronous clear.
// Wraps silently from all-ones to zero.
module perf_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-entry pipeline register from MEM, register-file
// write port, hazard/debug taps and a retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MEM2WB_BUS_SIZE-1:0] mem2wb_bus_i,
    input  logic                       ctl_mem_over_i,
    output logic                       ctl_wb_allowin_o,
    input  logic                       stall_i,
    output logic                       rf_we_o,
    output logic [REG_ADDR_BUS_W-1:0]  rf_waddr_o,
    output logic [REG_W-1:0]           rf_wdata_o,
    output logic [4:0]                 ctl_wb_dest_o,
    output logic [31:0]                ctl_wb_pc_o,
    output logic [31:0]                debug_wb_pc_o,
    output logic [3:0]                 debug_wb_rf_wen_o,
    output logic [4:0]                 debug_wb_rf_wnum_o,
    output logic [31:0]                debug_wb_rf_wdata_o,
    output logic                       retire_o,
    output logic [63:0]                instret_o
);

    logic        wb_valid_q, wb_valid_d;
    mem2wb_bus_t wb_bus_q, wb_bus_d;
    logic        ready_go;
    logic        allowin;
    logic        retire;
    logic        unused_addr;

    always_comb begin
        ready_go   = !stall_i;
        allowin    = !wb_valid_q || ready_go;
        retire     = wb_valid_q && ready_go;
        wb_valid_d = wb_valid_q;
        wb_bus_d   = wb_bus_q;
        if (allowin) begin
            wb_valid_d = ctl_mem_over_i;
            if (ctl_mem_over_i) begin
                wb_bus_d = mem2wb_bus_t'(mem2wb_bus_i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_bus_q   <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_bus_q   <= wb_bus_d;
        end
    end

    // Write only on the retiring cycle, so a stalled instruction writes once.
    assign rf_we_o             = retire && wb_bus_q.we && (wb_bus_q.wdest != '0);
    assign rf_waddr_o          = wb_bus_q.wdest;
    assign rf_wdata_o          = wb_bus_q.result;
    assign ctl_wb_allowin_o    = allowin;
    assign ctl_wb_dest_o       = wb_bus_q.wdest & {5{wb_valid_q}};
    assign ctl_wb_pc_o         = wb_bus_q.pc;
    assign debug_wb_pc_o       = wb_bus_q.pc;
    assign debug_wb_rf_wen_o   = {4{rf_we_o}};
    assign debug_wb_rf_wnum_o  = wb_bus_q.wdest;
    assign debug_wb_rf_wdata_o = wb_bus_q.result;
    assign retire_o            = retire;

    // The address field travels with the instruction for tracing only.
    assign unused_addr = ^wb_bus_q.addr;

    perf_counter64 u_instret (
        .clk   (clk),
        .rst   (rst),
        .en_i  (retire),
        .cnt_o (instret_o)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected retirements,
// a negedge monitor pops and compares whenever retire_o is seen.
module tb_wb_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [101:0] mem2wb_bus_i;
    logic         ctl_mem_over_i;
    logic         ctl_wb_allowin_o;
    logic         stall_i;
    logic         rf_we_o;
    logic [4:0]   rf_waddr_o;
    logic [31:0]  rf_wdata_o;
    logic [4:0]   ctl_wb_dest_o;
    logic [31:0]  ctl_wb_pc_o;
    logic [31:0]  debug_wb_pc_o;
    logic [3:0]   debug_wb_rf_wen_o;
    logic [4:0]   debug_wb_rf_wnum_o;
    logic [31:0]  debug_wb_rf_wdata_o;
    logic         retire_o;
    logic [63:0]  instret_o;

    wb_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem2wb_bus_i        (mem2wb_bus_i),
        .ctl_mem_over_i      (ctl_mem_over_i),
        .ctl_wb_allowin_o    (ctl_wb_allowin_o),
        .stall_i             (stall_i),
        .rf_we_o             (rf_we_o),
        .rf_waddr_o          (rf_waddr_o),
        .rf_wdata_o          (rf_wdata_o),
        .ctl_wb_dest_o       (ctl_wb_dest_o),
        .ctl_wb_pc_o         (ctl_wb_pc_o),
        .debug_wb_pc_o       (debug_wb_pc_o),
        .debug_wb_rf_wen_o   (debug_wb_rf_wen_o),
        .debug_wb_rf_wnum_o  (debug_wb_rf_wnum_o),
        .debug_wb_rf_wdata_o (debug_wb_rf_wdata_o),
        .retire_o            (retire_o),
        .instret_o           (instret_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] model_instret = '0;
    int          retire_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one MEM-over beat; push=1 records the expected retirement.
    task automatic drive(input logic [4:0] d, input logic we, input logic [31:0] res,
                         input logic [31:0] pc, input logic push);
        exp_t e;
        mem2wb_bus_i   = {d, we, res, pc ^ 32'h5A5A_0000, pc};
        ctl_mem_over_i = 1'b1;
        if (push) begin
            e.waddr = d; e.we = we; e.wdata = res; e.pc = pc;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            model_instret = '0;
        end else begin
            chk("rf_we_without_retire", {63'd0, rf_we_o && !retire_o}, 64'd0);
            if (retire_o) begin
                retire_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire_pc", {32'd0, debug_wb_pc_o}, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rf_we", {63'd0, rf_we_o}, {63'd0, e.we && (e.waddr != 5'd0)});
                    chk("rf_waddr", {59'd0, rf_waddr_o}, {59'd0, e.waddr});
                    chk("rf_wdata", {32'd0, rf_wdata_o}, {32'd0, e.wdata});
                    chk("dbg_pc", {32'd0, debug_wb_pc_o}, {32'd0, e.pc});
                    chk("dbg_wen", {60'd0, debug_wb_rf_wen_o},
                        {60'd0, {4{e.we && (e.waddr != 5'd0)}}});
                end
                chk("instret_before", instret_o, model_instret);
                model_instret = model_instret + 64'd1;
            end
        end
    end

    initial begin
        int r0;
        rst            = 1'b1;
        stall_i        = 1'b0;
        ctl_mem_over_i = 1'b0;
        mem2wb_bus_i   = '0;
        #2;
        chk("rst_rf_we", {63'd0, rf_we_o}, 64'd0);
        chk("rst_retire", {63'd0, retire_o}, 64'd0);
        chk("rst_dest", {59'd0, ctl_wb_dest_o}, 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        chk("rst_dbg", {debug_wb_pc_o, debug_wb_rf_wdata_o}, 64'd0);
        chk("rst_allowin", {63'd0, ctl_wb_allowin_o}, 64'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Basic write, accepted on first edge after reset
        drive(5'd5, 1'b1, 32'hDEAD_BEEF, 32'h1C00_0000, 1'b1);
        @(posedge clk); #1;
        ctl_mem_over_i = 1'b0;
        chk("basic_dest", {59'd0, ctl_wb_dest_o}, 64'd5);
        @(posedge clk); #1;
        chk("basic_instret", instret_o, 64'd1);

        // r0 write suppressed but counted
        drive(5'd0, 1'b1, 32'h1234_5678, 32'h1C00_0004, 1'b1);
        @(posedge clk); #1;
        ctl_mem_over_i = 1'b0;
        @(negedge clk);
        chk("r0_retire", {63'd0, retire_o}, 64'd1);
        chk("r0_rf_we", {63'd0, rf_we_o}, 64'd0);
        @(posedge clk); #1;
        chk("r0_instret", instret_o, 64'd2);

        // Stall for 3 cycles while MEM keeps offering a different instruction
        drive(5'd7, 1'b1, 32'hCAFE_0007, 32'h1C00_0008, 1'b1);
        @(posedge clk); #1;
        stall_i = 1'b1;
        drive(5'd9, 1'b1, 32'hBAD0_0009, 32'h1C00_000C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_allowin", {63'd0, ctl_wb_allowin_o}, 64'd0);
            chk("stall_rf_we", {63'd0, rf_we_o}, 64'd0);
            chk("stall_dest", {59'd0, ctl_wb_dest_o}, 64'd7);
            @(posedge clk); #1;
        end
        chk("stall_instret_held", instret_o, 64'd2);
        stall_i = 1'b0;
        ctl_mem_over_i = 1'b0;
        r0 = retire_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_single_retire", 64'(retire_cnt - r0), 64'd1);
        chk("stall_instret", instret_o, 64'd3);

        // Four back-to-back from a clean reset
        do_reset();
        r0 = retire_cnt;
        drive(5'd1, 1'b1, 32'h0000_0011, 32'h2000_0000, 1'b1);
        @(posedge clk); #1;
        drive(5'd2, 1'b0, 32'h0000_0022, 32'h2000_0004, 1'b1);
        @(posedge clk); #1;
        drive(5'd3, 1'b1, 32'h0000_0033, 32'h2000_0008, 1'b1);
        @(posedge clk); #1;
        drive(5'd31, 1'b1, 32'hFFFF_0044, 32'h2000_000C, 1'b1);
        @(posedge clk); #1;
        ctl_mem_over_i = 1'b0;
        @(posedge clk); #1;
        chk("b2b_retires", 64'(retire_cnt - r0), 64'd4);
        chk("b2b_instret", instret_o, 64'd4);

        // Reset mid-cycle while stalled drops the held instruction
        drive(5'd12, 1'b1, 32'h0BAD_F00D, 32'h3000_0000, 1'b1);
        @(posedge clk); #1;
        ctl_mem_over_i = 1'b0;
        stall_i = 1'b1;
        @(negedge clk); #2;
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("midrst_dest", {59'd0, ctl_wb_dest_o}, 64'd0);
        chk("midrst_rf_we", {63'd0, rf_we_o}, 64'd0);
        chk("midrst_instret", instret_o, 64'd0);
        chk("midrst_dbg_wdata", {32'd0, debug_wb_rf_wdata_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        stall_i = 1'b0;
        r0 = retire_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_retire", 64'(retire_cnt - r0), 64'd0);

        // Counter wrap
        @(negedge clk); #1;
        force dut.u_instret.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_instret.cnt_q;
        model_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        drive(5'd4, 1'b1, 32'h0000_0404, 32'h4000_0000, 1'b1);
        @(posedge clk); #1;
        ctl_mem_over_i = 1'b0;
        @(posedge clk); #1;
        chk("wrap_instret", instret_o, 64'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
